// File: rtl/arcino_multdiv_iter.sv
// ARCINO iterative multiply/divide unit for the EX stage.
// Fixed 34-edge latency: INIT, 32 COMP steps, FIN, then a DONE pulse.
module arcino_multdiv_iter #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [1:0]       operator_i,
    input  logic [1:0]       signed_mode_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o
);

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_COMP,
        S_FIN,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    md_op_e      op_q, op_d;
    logic [1:0]  sm_q, sm_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [63:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic        div0_q, div0_d;
    logic        ovf_q, ovf_d;
    logic [31:0] result_q, result_d;
    logic        busy_q;
    logic        valid_q;

    // Operand sign analysis used when entering the compute loop.
    logic        is_div;
    logic        sdiv;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    // One restoring-division step and one shift-add step.
    logic [32:0] rem_sh;
    logic        rem_ge;
    logic [31:0] rem_sub;
    logic [32:0] mul_sum;

    // Final sign correction.
    logic [63:0] prod;
    logic [31:0] div_val;
    logic [31:0] div_res;

    assign is_div  = op_q[1];
    assign sdiv    = (sm_q == 2'b11);
    assign a_neg   = a_q[31] & (is_div ? sdiv : sm_q[0]);
    assign b_neg   = b_q[31] & sdiv;
    assign mag_a   = a_neg ? (32'd0 - a_q) : a_q;
    assign mag_b   = b_neg ? (32'd0 - b_q) : b_q;

    assign rem_sh  = {acc_q[63:32], acc_q[31]};
    assign rem_ge  = (rem_sh >= {1'b0, b_q});
    assign rem_sub = rem_sh[31:0] - b_q;
    assign mul_sum = {1'b0, acc_q[63:32]}
                   + (acc_q[0] ? {1'b0, b_q} : 33'd0);

    assign prod    = neg_q ? (64'd0 - acc_q) : acc_q;
    assign div_val = (op_q == MD_OP_DIV) ? acc_q[31:0]
                                         : acc_q[63:32];
    assign div_res = neg_q ? (32'd0 - div_val) : div_val;

    // State register and all datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            op_q     <= MD_OP_MULL;
            sm_q     <= 2'b00;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sm_q     <= sm_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            busy_q   <= (state_d != S_IDLE);
            valid_q  <= (state_d == S_DONE);
        end
    end

    // Next-state sequencing; a flush returns to IDLE from anywhere.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: if (start_i) state_d = S_INIT;
                S_INIT: state_d = S_COMP;
                S_COMP: if (cnt_q == 5'(ITER - 1)) state_d = S_FIN;
                S_FIN:  state_d = S_DONE;
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath: capture, magnitude setup, iterate, then sign-correct.
    always_comb begin
        op_d     = op_q;
        sm_d     = sm_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    op_d = md_op_e'(operator_i);
                    sm_d = signed_mode_i;
                    a_d  = op_a_i;
                    b_d  = op_b_i;
                end
            end
            S_INIT: begin
                cnt_d  = 5'd0;
                div0_d = (b_q == 32'd0);
                ovf_d  = sdiv && (a_q == 32'h8000_0000)
                              && (b_q == 32'hFFFF_FFFF);
                if (is_div) begin
                    acc_d = {32'd0, mag_a};
                    b_d   = mag_b;
                    neg_d = (op_q == MD_OP_REM) ? a_neg
                                                : (a_neg ^ b_neg);
                end else begin
                    acc_d = {32'd0, mag_b};
                    b_d   = mag_a;
                    neg_d = a_neg ^ b_neg;
                end
            end
            S_COMP: begin
                cnt_d = cnt_q + 5'd1;
                if (is_div) begin
                    if (rem_ge) acc_d = {rem_sub, acc_q[30:0], 1'b1};
                    else        acc_d = {rem_sh[31:0], acc_q[30:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[31:1]};
                end
            end
            S_FIN: begin
                if (!flush_i) begin
                    if (!is_div) begin
                        result_d = (op_q == MD_OP_MULL) ? prod[31:0]
                                                        : prod[63:32];
                    end else if (div0_q) begin
                        result_d = (op_q == MD_OP_DIV) ? 32'hFFFF_FFFF
                                                       : a_q;
                    end else if (ovf_q) begin
                        result_d = (op_q == MD_OP_DIV) ? 32'h8000_0000
                                                       : 32'd0;
                    end else begin
                        result_d = div_res;
                    end
                end
            end
            default: ;
        endcase
    end

    assign busy_o   = busy_q;
    assign valid_o  = valid_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_arcino_multdiv_iter.sv
// Scoreboard bench for arcino_multdiv_iter.
// Stimulus pushes expected result and due cycle; a monitor checks valid_o.
module tb_arcino_multdiv_iter;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [1:0]  operator_i = 2'd0;
    logic [1:0]  signed_mode_i = 2'd0;
    logic [31:0] op_a_i = '0;
    logic [31:0] op_b_i = '0;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    logic [31:0] last_res = '0;

    arcino_multdiv_iter dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .flush_i      (flush_i),
        .operator_i   (operator_i),
        .signed_mode_i(signed_mode_i),
        .op_a_i       (op_a_i),
        .op_b_i       (op_b_i),
        .busy_o       (busy_o),
        .valid_o      (valid_o),
        .result_o     (result_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain arithmetic from the operation rules.
    function automatic logic [31:0] ref_md(input logic [1:0] op,
                                           input logic [1:0] sm,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic signed [63:0] pa, pb, pr;
        int sa, sb;
        if (op < 2) begin
            pa = sm[0] ? {{32{a[31]}}, a} : {32'd0, a};
            pb = (sm == 2'b11) ? {{32{b[31]}}, b} : {32'd0, b};
            pr = pa * pb;
            return (op == 0) ? pr[31:0] : pr[63:32];
        end
        if (b == 0) return (op == 2) ? 32'hFFFF_FFFF : a;
        if (sm == 2'b11) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return (op == 2) ? 32'h8000_0000 : 32'd0;
            sa = a;
            sb = b;
            return (op == 2) ? 32'(sa / sb) : 32'(sa % sb);
        end
        return (op == 2) ? (a / b) : (a % b);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every valid_o pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst_i && valid_o) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_valid: result %h at cycle %0d",
                         result_o, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result", result_o, e.res);
                check("latency", 32'(cyc), 32'(e.due));
                last_res = e.res;
            end
        end
    end

    // Start one operation in IDLE; optionally register its expectation.
    task automatic issue(input logic [1:0] op, input logic [1:0] sm,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input bit push);
        exp_t e;
        @(negedge clk);
        check("busy_before_start", 32'(busy_o), 32'd0);
        operator_i    = op;
        signed_mode_i = sm;
        op_a_i        = a;
        op_b_i        = b;
        start_i       = 1'b1;
        if (push) begin
            e.res = res;
            e.due = cyc + 35;
            sb_q.push_back(e);
        end
        @(negedge clk);
        start_i       = 1'b0;
        operator_i    = 2'($urandom);
        signed_mode_i = 2'($urandom);
        op_a_i        = $urandom;
        op_b_i        = $urandom;
        check("busy_after_start", 32'(busy_o), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy_o && n < 60);
        if (busy_o) begin
            n_chk++;
            n_fail++;
            $display("FAIL idle_timeout: busy_o still 1 after %0d cycles", n);
        end
    endtask

    task automatic run(input logic [1:0] op, input logic [1:0] sm,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res);
        issue(op, sm, a, b, res, 1'b1);
        wait_idle();
        check("result_hold", result_o, res);
    endtask

    function automatic logic [31:0] pick();
        int s;
        s = $urandom_range(0, 7);
        case (s)
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] held;
        logic [1:0]  rop, rsm;
        logic [31:0] ra, rb;

        #1;
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_valid", 32'(valid_o), 32'd0);
        check("reset_result", result_o, 32'd0);
        @(negedge clk);
        rst_i = 1'b0;

        run(2'd0, 2'b11, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run(2'd1, 2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run(2'd1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run(2'd1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(2'd1, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run(2'd2, 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run(2'd3, 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run(2'd2, 2'b00, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);
        run(2'd3, 2'b00, 32'hFFFF_FFF9, 32'd2, 32'd1);
        run(2'd2, 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run(2'd3, 2'b00, 32'd5, 32'd0, 32'd5);
        run(2'd2, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run(2'd3, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run(2'd3, 2'b11, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);

        // Flush mid-operation: no valid, result unchanged.
        held = result_o;
        issue(2'd0, 2'b00, 32'd100, 32'd100, 32'd0, 1'b0);
        repeat (8) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush_busy", 32'(busy_o), 32'd0);
        check("flush_result", result_o, held);
        run(2'd0, 2'b00, 32'd6, 32'd9, 32'd54);

        // Start together with flush in IDLE is dropped.
        @(negedge clk);
        start_i = 1'b1;
        flush_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        flush_i = 1'b0;
        check("flush_start_busy", 32'(busy_o), 32'd0);

        // Stray start during COMP is ignored.
        issue(2'd2, 2'b00, 32'd1000, 32'd7, 32'd142, 1'b1);
        repeat (5) @(negedge clk);
        operator_i = 2'd0;
        op_a_i     = 32'd3;
        op_b_i     = 32'd3;
        start_i    = 1'b1;
        @(negedge clk);
        start_i    = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);
        check("stray_hold", result_o, 32'd142);

        // Asynchronous reset during a divide.
        issue(2'd2, 2'b11, 32'd12345, 32'd7, 32'd0, 1'b0);
        repeat (18) @(negedge clk);
        #2 rst_i = 1'b1;
        #1;
        check("areset_busy", 32'(busy_o), 32'd0);
        check("areset_valid", 32'(valid_o), 32'd0);
        check("areset_result", result_o, 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        run(2'd0, 2'b00, 32'd3, 32'd4, 32'd12);

        // Randomized operations against the reference.
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            rsm = 2'($urandom_range(0, 3));
            ra  = pick();
            rb  = pick();
            run(rop, rsm, ra, rb, ref_md(rop, rsm, ra, rb));
        end

        repeat (5) @(negedge clk);
        while (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL missing_valid: expected %h due %0d", e.res, e.due);
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
